// File: rtl/inv_sqrt_wb_host_if.sv
// inv_sqrt_wb_host_if: Wishbone slave bus plus command/response stream between host and accelerator
interface inv_sqrt_wb_host_if #(parameter int DATA_W = 16);
    logic [1:0]        i_wb_adr;
    logic [31:0]       i_wb_dat;
    logic [3:0]        i_wb_sel;
    logic              i_wb_we;
    logic              i_wb_cyc;
    logic              i_wb_stb;
    logic [31:0]       o_wb_rdt;
    logic              o_wb_ack;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_valid;
    logic              rsp_ready;
    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb, cmd_ready, rsp_data, rsp_valid,
        output o_wb_rdt, o_wb_ack, cmd_data, cmd_valid, rsp_ready
    );
    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb, cmd_ready, rsp_data, rsp_valid,
        input  o_wb_rdt, o_wb_ack, cmd_data, cmd_valid, rsp_ready
    );
endinterface

// File: rtl/inv_sqrt_wb_host.sv
// inv_sqrt_wb_host: Wishbone front end feeding the inverse-square-root accelerator through in/out FIFOs
module inv_sqrt_wb_host #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    inv_sqrt_wb_host_if.slave   bus,
    output logic                irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] in_mem_q [DEPTH];
    logic [DATA_W-1:0] out_mem_q [DEPTH];
    logic [AW-1:0] in_rd_q, in_rd_d, in_wr_q, in_wr_d, out_rd_q, out_rd_d, out_wr_q, out_wr_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic busy_q, busy_d, ovf_q, ovf_d, unf_q, unf_d, irq_en_q, irq_en_d;
    logic ack_q, ack_d, irq_q, irq_d;
    logic [31:0] rdt_q, rdt_d, status, rd_val;
    logic req, wr, rd, cmd_pop, push_in, pop_out, rsp_push, flush, clear, ovf_set, unf_set;
    logic unused_bits;

    assign req      = bus.i_wb_cyc & bus.i_wb_stb & ~ack_q;
    assign wr       = req & bus.i_wb_we;
    assign rd       = req & ~bus.i_wb_we;
    assign cmd_pop  = bus.cmd_valid & bus.cmd_ready;
    // a full input FIFO still accepts a write when the head leaves on the same edge
    assign push_in  = wr && bus.i_wb_adr == 2'd0 && (in_cnt_q != FULL || cmd_pop);
    assign ovf_set  = wr && bus.i_wb_adr == 2'd0 && in_cnt_q == FULL && !cmd_pop;
    assign pop_out  = rd && bus.i_wb_adr == 2'd1 && out_cnt_q != '0;
    assign unf_set  = rd && bus.i_wb_adr == 2'd1 && out_cnt_q == '0;
    assign rsp_push = bus.rsp_valid & busy_q;
    assign flush    = wr && bus.i_wb_adr == 2'd3 && bus.i_wb_dat[1];
    assign clear    = wr && bus.i_wb_adr == 2'd3 && bus.i_wb_dat[0];

    assign status = {12'd0, 4'(out_cnt_q), 4'd0, 4'(in_cnt_q), 1'b0, unf_q, ovf_q, busy_q,
                     out_cnt_q == '0, out_cnt_q == FULL, in_cnt_q == '0, in_cnt_q == FULL};
    assign rd_val = bus.i_wb_adr == 2'd1 ? (out_cnt_q != '0 ? 32'(out_mem_q[out_rd_q]) : 32'd0) :
                    bus.i_wb_adr == 2'd2 ? status :
                    bus.i_wb_adr == 2'd3 ? {29'd0, irq_en_q, 2'b00} : 32'd0;

    // output-FIFO space is reserved at issue time, so a response can always be stored
    assign bus.cmd_valid = ~busy_q && in_cnt_q != '0 && out_cnt_q != FULL;
    assign bus.cmd_data  = in_mem_q[in_rd_q];
    assign bus.rsp_ready = busy_q;
    assign bus.o_wb_ack  = ack_q;
    assign bus.o_wb_rdt  = rdt_q;
    assign irq           = irq_q;
    assign unused_bits   = ^{bus.i_wb_sel, bus.i_wb_dat[31:DATA_W]};

    always_comb begin
        in_wr_d   = in_wr_q + AW'(push_in);
        in_rd_d   = in_rd_q + AW'(cmd_pop);
        in_cnt_d  = in_cnt_q + CW'(push_in) - CW'(cmd_pop);
        out_wr_d  = out_wr_q + AW'(rsp_push);
        out_rd_d  = out_rd_q + AW'(pop_out);
        out_cnt_d = out_cnt_q + CW'(rsp_push) - CW'(pop_out);
        if (flush) begin
            in_wr_d   = '0;
            in_rd_d   = '0;
            in_cnt_d  = '0;
            out_wr_d  = '0;
            out_rd_d  = '0;
            out_cnt_d = '0;
        end
        busy_d   = cmd_pop | (busy_q & ~rsp_push);
        ovf_d    = ~clear & (ovf_q | ovf_set);
        unf_d    = ~clear & (unf_q | unf_set);
        irq_en_d = (wr && bus.i_wb_adr == 2'd3) ? bus.i_wb_dat[2] : irq_en_q;
        ack_d    = req;
        rdt_d    = rd ? rd_val : 32'd0;
        irq_d    = irq_en_q & (out_cnt_q != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_cnt_q  <= '0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            ack_q     <= 1'b0;
            rdt_q     <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            in_wr_q   <= in_wr_d;
            in_rd_q   <= in_rd_d;
            in_cnt_q  <= in_cnt_d;
            out_wr_q  <= out_wr_d;
            out_rd_q  <= out_rd_d;
            out_cnt_q <= out_cnt_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            irq_en_q  <= irq_en_d;
            ack_q     <= ack_d;
            rdt_q     <= rdt_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_in) in_mem_q[in_wr_q] <= bus.i_wb_dat[DATA_W-1:0];
        if (rsp_push) out_mem_q[out_wr_q] <= bus.rsp_data;
    end
endmodule
